// File: rtl/regfile_wb_queue.sv
// Register-file write-back queue: in-order FIFO of ALU/load write requests drained into a registered write port.
// Optional pending-data bypass is enabled by defining REGFILE_WB_BYPASS_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module regfile_wb_queue #(
    parameter int WIDTH = `WORD_SIZE,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mem_valid,
    input  logic [4:0]       i_mem_rd,
    input  logic [WIDTH-1:0] i_mem_data,
    output logic             o_mem_ready,
    input  logic             i_alu_valid,
    input  logic [4:0]       i_alu_rd,
    input  logic [WIDTH-1:0] i_alu_data,
    output logic             o_alu_ready,
    input  logic             i_stall,
    output logic             o_Wen,
    output logic [4:0]       o_Wnum,
    output logic [WIDTH-1:0] o_Wd,
    output logic             o_empty,
    output logic             o_full,
    input  logic [4:0]       i_Rnum1,
    input  logic [4:0]       i_Rnum2,
    output logic             o_fwd1_hit,
    output logic [WIDTH-1:0] o_fwd1_data,
    output logic             o_fwd2_hit,
    output logic [WIDTH-1:0] o_fwd2_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       entry_rd_q   [DEPTH];
    logic [4:0]       entry_rd_d   [DEPTH];
    logic [WIDTH-1:0] entry_data_q [DEPTH];
    logic [WIDTH-1:0] entry_data_d [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wen_q, wen_d;
    logic [4:0]       wnum_q, wnum_d;
    logic [WIDTH-1:0] wd_q, wd_d;

    logic             full;
    logic             empty;
    logic             mem_fire;
    logic             alu_fire;
    logic [4:0]       push_rd;
    logic [WIDTH-1:0] push_data;
    logic             push_en;
    logic             pop_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Load path has fixed priority; readies depend only on the registered count, so a pop never frees a slot early.
    assign o_mem_ready = !full;
    assign o_alu_ready = !full && !i_mem_valid;

    assign mem_fire  = i_mem_valid && o_mem_ready;
    assign alu_fire  = i_alu_valid && o_alu_ready;
    assign push_rd   = mem_fire ? i_mem_rd : i_alu_rd;
    assign push_data = mem_fire ? i_mem_data : i_alu_data;
    // Writes to r0 complete their handshake but are dropped.
    assign push_en   = (mem_fire || alu_fire) && (push_rd != 5'd0);
    assign pop_en    = !empty && !i_stall;

    always_comb begin
        entry_rd_d   = entry_rd_q;
        entry_data_d = entry_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CW'(push_en) - CW'(pop_en);
        wen_d        = pop_en;
        wnum_d       = wnum_q;
        wd_d         = wd_q;

        if (push_en) begin
            entry_rd_d[wr_ptr_q]   = push_rd;
            entry_data_d[wr_ptr_q] = push_data;
            wr_ptr_d               = wr_ptr_q + AW'(1);
        end

        if (pop_en) begin
            wnum_d   = entry_rd_q[rd_ptr_q];
            wd_d     = entry_data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wen_q    <= 1'b0;
            wnum_q   <= '0;
            wd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            wnum_q   <= wnum_d;
            wd_q     <= wd_d;
        end
    end

    // Storage needs no reset: slots are only visible through count/pointers.
    always_ff @(posedge i_clk) begin
        entry_rd_q   <= entry_rd_d;
        entry_data_q <= entry_data_d;
    end

    assign o_Wen   = wen_q;
    assign o_Wnum  = wnum_q;
    assign o_Wd    = wd_q;
    assign o_empty = empty;
    assign o_full  = full;

`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0] slot;

    // Scan oldest to newest so the last match (tail side) wins; the output stage is older than every queued entry.
    always_comb begin
        o_fwd1_hit  = 1'b0;
        o_fwd1_data = '0;
        o_fwd2_hit  = 1'b0;
        o_fwd2_data = '0;
        slot        = '0;

        if (wen_q && (i_Rnum1 != 5'd0) && (wnum_q == i_Rnum1)) begin
            o_fwd1_hit  = 1'b1;
            o_fwd1_data = wd_q;
        end
        if (wen_q && (i_Rnum2 != 5'd0) && (wnum_q == i_Rnum2)) begin
            o_fwd2_hit  = 1'b1;
            o_fwd2_data = wd_q;
        end

        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) begin
                if ((i_Rnum1 != 5'd0) && (entry_rd_q[slot] == i_Rnum1)) begin
                    o_fwd1_hit  = 1'b1;
                    o_fwd1_data = entry_data_q[slot];
                end
                if ((i_Rnum2 != 5'd0) && (entry_rd_q[slot] == i_Rnum2)) begin
                    o_fwd2_hit  = 1'b1;
                    o_fwd2_data = entry_data_q[slot];
                end
            end
        end
    end
`else
    logic unused_rnum;

    assign unused_rnum = ^{i_Rnum1, i_Rnum2};
    assign o_fwd1_hit  = 1'b0;
    assign o_fwd1_data = '0;
    assign o_fwd2_hit  = 1'b0;
    assign o_fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: queue-based reference model compared every cycle plus directed literal checks.
// Bypass checks follow REGFILE_WB_BYPASS_EN, matching the build of the design.
`timescale 1ns/1ps

module tb_regfile_wb_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_mem_valid = 1'b0;
    logic [4:0]       i_mem_rd = '0;
    logic [WIDTH-1:0] i_mem_data = '0;
    logic             o_mem_ready;
    logic             i_alu_valid = 1'b0;
    logic [4:0]       i_alu_rd = '0;
    logic [WIDTH-1:0] i_alu_data = '0;
    logic             o_alu_ready;
    logic             i_stall = 1'b0;
    logic             o_Wen;
    logic [4:0]       o_Wnum;
    logic [WIDTH-1:0] o_Wd;
    logic             o_empty;
    logic             o_full;
    logic [4:0]       i_Rnum1 = '0;
    logic [4:0]       i_Rnum2 = '0;
    logic             o_fwd1_hit;
    logic [WIDTH-1:0] o_fwd1_data;
    logic             o_fwd2_hit;
    logic [WIDTH-1:0] o_fwd2_data;

    int vectors = 0;
    int miscompares = 0;

    regfile_wb_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_mem_valid(i_mem_valid), .i_mem_rd(i_mem_rd), .i_mem_data(i_mem_data), .o_mem_ready(o_mem_ready),
        .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data), .o_alu_ready(o_alu_ready),
        .i_stall(i_stall), .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd),
        .o_empty(o_empty), .o_full(o_full),
        .i_Rnum1(i_Rnum1), .i_Rnum2(i_Rnum2),
        .o_fwd1_hit(o_fwd1_hit), .o_fwd1_data(o_fwd1_data),
        .o_fwd2_hit(o_fwd2_hit), .o_fwd2_data(o_fwd2_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           m_q[$];
    logic             m_wen = 1'b0;
    logic [4:0]       m_wnum = '0;
    logic [WIDTH-1:0] m_wd = '0;

    // Reference model: a plain queue; pop decided on the pre-edge occupancy, push blocked whenever pre-edge full.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_q.delete();
            m_wen  = 1'b0;
            m_wnum = '0;
            m_wd   = '0;
        end else begin
            automatic bit     was_full = (m_q.size() == DEPTH);
            automatic entry_t e;
            if (m_q.size() != 0 && !i_stall) begin
                e      = m_q.pop_front();
                m_wen  = 1'b1;
                m_wnum = e.rd;
                m_wd   = e.data;
            end else begin
                m_wen = 1'b0;
            end
            if (!was_full) begin
                if (i_mem_valid) begin
                    if (i_mem_rd != 0) m_q.push_back('{rd: i_mem_rd, data: i_mem_data});
                end else if (i_alu_valid) begin
                    if (i_alu_rd != 0) m_q.push_back('{rd: i_alu_rd, data: i_alu_data});
                end
            end
        end
    end

    function automatic logic [WIDTH:0] model_fwd(input logic [4:0] rnum);
        logic [WIDTH:0] r;
        r = '0;
`ifdef REGFILE_WB_BYPASS_EN
        if (rnum != 0) begin
            if (m_wen && m_wnum == rnum) r = {1'b1, m_wd};
            foreach (m_q[k]) begin
                if (m_q[k].rd == rnum) r = {1'b1, m_q[k].data};
            end
        end
`endif
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, away from the active edge, compare all outputs against the model.
    always @(negedge i_clk) begin
        automatic logic [WIDTH:0] f1 = model_fwd(i_Rnum1);
        automatic logic [WIDTH:0] f2 = model_fwd(i_Rnum2);
        automatic bit m_full = (m_q.size() == DEPTH);
        check_output("cyc_wen",       32'(o_Wen),       32'(m_wen));
        check_output("cyc_wnum",      32'(o_Wnum),      32'(m_wnum));
        check_output("cyc_wd",        o_Wd,             m_wd);
        check_output("cyc_empty",     32'(o_empty),     32'(m_q.size() == 0));
        check_output("cyc_full",      32'(o_full),      32'(m_full));
        check_output("cyc_mem_ready", 32'(o_mem_ready), 32'(!m_full));
        check_output("cyc_alu_ready", 32'(o_alu_ready), 32'(!m_full && !i_mem_valid));
        check_output("cyc_fwd1_hit",  32'(o_fwd1_hit),  32'(f1[WIDTH]));
        check_output("cyc_fwd1_data", o_fwd1_data,      f1[WIDTH-1:0]);
        check_output("cyc_fwd2_hit",  32'(o_fwd2_hit),  32'(f2[WIDTH]));
        check_output("cyc_fwd2_data", o_fwd2_data,      f2[WIDTH-1:0]);
    end

    task automatic apply_stimulus(input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                                  input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                  input logic stall);
        i_mem_valid = mv;
        i_mem_rd    = mrd;
        i_mem_data  = mdata;
        i_alu_valid = av;
        i_alu_rd    = ard;
        i_alu_data  = adata;
        i_stall     = stall;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_output("rst_wen",   32'(o_Wen),       32'd0);
        check_output("rst_empty", 32'(o_empty),     32'd1);
        check_output("rst_full",  32'(o_full),      32'd0);
        check_output("rst_mrdy",  32'(o_mem_ready), 32'd1);
        i_rst = 1'b0;
        tick();

        // Single ALU write: visible one edge after acceptance, gone the edge after
        apply_stimulus(0, 0, 0, 1, 5'd5, 32'hA5, 0);
        tick();
        check_output("t2_wen_e0",  32'(o_Wen),   32'd0);
        check_output("t2_nempty",  32'(o_empty), 32'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("t2_wen_e1",  32'(o_Wen),  32'd1);
        check_output("t2_wnum_e1", 32'(o_Wnum), 32'd5);
        check_output("t2_wd_e1",   o_Wd,        32'hA5);
        tick();
        check_output("t2_wen_e2",  32'(o_Wen),  32'd0);
        check_output("t2_wnum_hold", 32'(o_Wnum), 32'd5);

        // Both paths valid: load wins, ALU retried next cycle
        apply_stimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0);
        #1;
        check_output("t3_mrdy", 32'(o_mem_ready), 32'd1);
        check_output("t3_ardy", 32'(o_alu_ready), 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 1, 5'd4, 32'h22, 0);
        #1;
        check_output("t3_ardy2", 32'(o_alu_ready), 32'd1);
        tick();
        check_output("t3_wnum_a", 32'(o_Wnum), 32'd3);
        check_output("t3_wd_a",   o_Wd,        32'h11);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("t3_wnum_b", 32'(o_Wnum), 32'd4);
        check_output("t3_wd_b",   o_Wd,        32'h22);
        tick();

        // Stalled fill to full, then drain in order; a push offered while full is refused
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, 0, 0, 1, 5'(k + 1), 32'h10 + 32'(k), 1);
            tick();
        end
        apply_stimulus(0, 0, 0, 1, 5'd9, 32'h99, 1);
        #1;
        check_output("t4_full",   32'(o_full),      32'd1);
        check_output("t4_mrdy",   32'(o_mem_ready), 32'd0);
        check_output("t4_ardy",   32'(o_alu_ready), 32'd0);
        check_output("t4_wen",    32'(o_Wen),       32'd0);
        check_output("t4_model",  32'(m_q.size()),  32'd4);
        tick();
        apply_stimulus(0, 0, 0, 1, 5'd9, 32'h99, 0);
        tick();
        check_output("t4_wen_0",  32'(o_Wen),  32'd1);
        check_output("t4_wnum_0", 32'(o_Wnum), 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_output("t4_wen_k",  32'(o_Wen),  32'd1);
            check_output("t4_wnum_k", 32'(o_Wnum), 32'(k + 1));
            check_output("t4_wd_k",   o_Wd,        32'h10 + 32'(k));
        end
        tick();
        check_output("t4_done_wen",   32'(o_Wen),   32'd0);
        check_output("t4_done_empty", 32'(o_empty), 32'd1);

        // Writes to r0 are consumed but never enqueued
        apply_stimulus(0, 0, 0, 1, 5'd0, 32'hFF, 0);
        #1;
        check_output("t5_ardy", 32'(o_alu_ready), 32'd1);
        tick();
        check_output("t5_empty", 32'(o_empty), 32'd1);
        apply_stimulus(1, 5'd0, 32'hFE, 0, 0, 0, 0);
        tick();
        check_output("t5_wen", 32'(o_Wen), 32'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("t5_wen2", 32'(o_Wen), 32'd0);

        // Bypass lookup with two pending writes to the same register
        apply_stimulus(1, 5'd7, 32'h1, 0, 0, 0, 1);
        tick();
        apply_stimulus(1, 5'd7, 32'h2, 0, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        i_Rnum1 = 5'd7;
        i_Rnum2 = 5'd0;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        check_output("t6_hit1",  32'(o_fwd1_hit), 32'd1);
        check_output("t6_data1", o_fwd1_data,     32'h2);
`else
        check_output("t6_hit1",  32'(o_fwd1_hit), 32'd0);
        check_output("t6_data1", o_fwd1_data,     32'h0);
`endif
        check_output("t6_hit2", 32'(o_fwd2_hit), 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick();
        i_Rnum1 = 5'd0;

        // Reset while draining: outputs clear immediately and nothing further retires
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 5'(10 + k), 32'hA0 + 32'(k), 0, 0, 0, 1);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("t1_wen_pre",  32'(o_Wen),  32'd1);
        check_output("t1_wnum_pre", 32'(o_Wnum), 32'd10);
        #2;
        i_rst = 1'b1;
        #1;
        check_output("t1_wen",   32'(o_Wen),   32'd0);
        check_output("t1_empty", 32'(o_empty), 32'd1);
        check_output("t1_wnum",  32'(o_Wnum),  32'd0);
        check_output("t1_wd",    o_Wd,         32'd0);
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("t1_no_wr", 32'(o_Wen), 32'd0);
        end

        // Directed mixed traffic: simultaneous push/pop, contention, stalls and lookups
        for (int k = 0; k < 48; k++) begin
            apply_stimulus((k % 3) == 0, 5'((k * 7) % 32), 32'h1000 + 32'(k),
                           (k % 2) == 0, 5'((k * 5 + 1) % 8), 32'h2000 + 32'(k),
                           (k % 5) == 1 || (k % 11) == 4);
            i_Rnum1 = 5'((k * 5) % 8);
            i_Rnum2 = 5'((k * 3) % 32);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) tick();
        check_output("end_empty", 32'(o_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
